// File: rtl/hs_npu_deskew_collector_if.sv
// hs_npu_deskew_collector_if: lane-input, row-output and control bundle of the deskew collector
interface hs_npu_deskew_collector_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 32
);
  logic flush;
  logic start_in;
  logic [31:0] enable_cycles_in;
  logic [LANES-1:0] lane_valid_i;
  logic [LANES*WIDTH-1:0] lane_data_i;
  logic valid_o;
  logic [LANES*WIDTH-1:0] out;
  logic ready_i;
  logic busy_o;
  logic done_o;
  logic overflow_o;
  modport slave (
    input flush, start_in, enable_cycles_in, lane_valid_i, lane_data_i, ready_i,
    output valid_o, out, busy_o, done_o, overflow_o
  );
  modport master (
    output flush, start_in, enable_cycles_in, lane_valid_i, lane_data_i, ready_i,
    input valid_o, out, busy_o, done_o, overflow_o
  );
endinterface

// File: rtl/hs_npu_deskew_collector.sv
// hs_npu_deskew_collector: realigns staggered per-lane streams into row words for the output FIFO
module hs_npu_deskew_collector #(
  parameter int LANES = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic clk_core,
  input logic rst_core,
  hs_npu_deskew_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;
  logic [0:0] state;
  logic [31:0] rows_total, rows_sent, sent_next;
  logic [WIDTH-1:0] mem [LANES][DEPTH];
  logic [AW-1:0] wptr [LANES];
  logic [AW-1:0] rptr [LANES];
  logic [AW:0] cnt [LANES];
  logic [LANES-1:0] full, push, wr, drop;
  logic [LANES*WIDTH-1:0] heads;
  logic all_ne, pop, last, finish, clear, done, overflow;
  always_comb begin
    heads = '0;
    full = '0;
    all_ne = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      heads[i*WIDTH +: WIDTH] = mem[i][rptr[i]];
      full[i] = cnt[i] == CAP;
      all_ne = all_ne && cnt[i] != '0;
    end
  end
  assign bus.valid_o = all_ne && state == COLLECT;
  assign bus.out = bus.valid_o ? heads : '0;
  assign bus.busy_o = state == COLLECT;
  assign bus.done_o = done;
  assign bus.overflow_o = overflow;
  assign pop = bus.valid_o && bus.ready_i;
  assign sent_next = rows_sent + 32'd1;
  assign last = pop && sent_next == rows_total;
  // the rows_sent == rows_total term only fires for a zero-length transfer
  assign finish = state == COLLECT && (last || rows_sent == rows_total);
  assign clear = rst_core || bus.flush || finish;
  assign push = bus.lane_valid_i & {LANES{state == COLLECT || bus.start_in}};
  assign wr = push & (~full | {LANES{pop}});
  assign drop = push & full & ~{LANES{pop}};
  always_ff @(posedge clk_core)
    if (rst_core || bus.flush) begin
      state <= IDLE;
      rows_total <= '0;
      rows_sent <= '0;
      done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= last || (state == IDLE && bus.start_in && bus.enable_cycles_in == '0);
      if (|drop) overflow <= 1'b1;
      if (state == IDLE && bus.start_in) begin
        state <= COLLECT;
        rows_total <= bus.enable_cycles_in;
        rows_sent <= '0;
      end else if (finish) state <= IDLE;
      else if (pop) rows_sent <= sent_next;
    end
  always_ff @(posedge clk_core)
    for (int i = 0; i < LANES; i++)
      if (clear) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i] <= '0;
      end else begin
        if (wr[i]) wptr[i] <= wptr[i] + AW'(1);
        if (pop) rptr[i] <= rptr[i] + AW'(1);
        cnt[i] <= cnt[i] + (AW+1)'(wr[i]) - (AW+1)'(pop);
      end
  always_ff @(posedge clk_core)
    for (int i = 0; i < LANES; i++)
      if (wr[i]) mem[i][wptr[i]] <= bus.lane_data_i[i*WIDTH +: WIDTH];
endmodule

// File: tb/tb_hs_npu_deskew_collector.sv
// tb_hs_npu_deskew_collector: scenario tasks checked against a queue-based model of the collector
module tb_hs_npu_deskew_collector;
  localparam int LANES = 4;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  hs_npu_deskew_collector_if #(.LANES(LANES), .WIDTH(WIDTH)) b();
  hs_npu_deskew_collector #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_core(clk),
    .rst_core(rst),
    .bus(b)
  );
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  int unsigned salt;
  int unsigned q[LANES][$];
  bit m_busy, m_ovf, m_done;
  int unsigned m_total, m_sent;
  logic [LANES*WIDTH-1:0] got[$];

  function automatic logic [WIDTH-1:0] lane_val(int k, int r);
    return WIDTH'(salt ^ 32'(32'h100 * k + r));
  endfunction

  function automatic logic [LANES*WIDTH-1:0] row(int r);
    row = '0;
    for (int k = 0; k < LANES; k++) row[k*WIDTH +: WIDTH] = lane_val(k, r);
  endfunction

  function automatic bit m_valid();
    m_valid = m_busy;
    for (int k = 0; k < LANES; k++) if (q[k].size() == 0) m_valid = 1'b0;
  endfunction

  function automatic logic [LANES*WIDTH-1:0] m_out();
    m_out = '0;
    if (m_valid()) for (int k = 0; k < LANES; k++) m_out[k*WIDTH +: WIDTH] = WIDTH'(q[k][0]);
  endfunction

  // one clock of the reference: rows leave as whole words, lanes keep at most DEPTH elements
  task automatic model_step();
    bit pop, last, fin;
    if (rst || b.flush) begin
      m_busy = 0; m_ovf = 0; m_done = 0; m_total = 0; m_sent = 0;
      for (int k = 0; k < LANES; k++) q[k].delete();
      return;
    end
    pop = m_valid() && b.ready_i;
    last = pop && (m_sent + 32'd1 == m_total);
    fin = m_busy && (m_sent == m_total || last);
    m_done = last || (!m_busy && b.start_in && b.enable_cycles_in == 0);
    if (pop) begin
      for (int k = 0; k < LANES; k++) void'(q[k].pop_front());
      m_sent++;
    end
    for (int k = 0; k < LANES; k++)
      if (b.lane_valid_i[k] && (m_busy || b.start_in)) begin
        if (q[k].size() < DEPTH) q[k].push_back(b.lane_data_i[k*WIDTH +: WIDTH]);
        else m_ovf = 1;
      end
    if (fin) begin
      m_busy = 0;
      for (int k = 0; k < LANES; k++) q[k].delete();
    end else if (!m_busy && b.start_in) begin
      m_busy = 1; m_total = b.enable_cycles_in; m_sent = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // lane k carries element r at cycle t0+k+r
  task automatic drive(int c, int t0, int e, bit rdy, bit st);
    b.start_in = st;
    b.enable_cycles_in = 32'(e);
    b.ready_i = rdy;
    for (int k = 0; k < LANES; k++) begin
      b.lane_valid_i[k] = (c - t0 - k >= 0) && (c - t0 - k < e);
      b.lane_data_i[k*WIDTH +: WIDTH] = b.lane_valid_i[k] ? lane_val(k, c - t0 - k) : '0;
    end
  endtask

  task automatic test_reset();
    b.flush = 0; b.start_in = 0; b.enable_cycles_in = 0; b.ready_i = 0;
    b.lane_valid_i = '0; b.lane_data_i = '0;
    rst = 1;
    tick(); tick();
    rst = 0;
    tests += 2;
    if ({b.valid_o, b.busy_o, b.done_o, b.overflow_o} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags got %b exp 0000", {b.valid_o, b.busy_o, b.done_o, b.overflow_o});
    end
    if (b.out !== '0) begin fails++; $display("FAIL reset_out got %h exp 0", b.out); end
  endtask

  task automatic test_basic();
    salt = 0;
    for (int c = 0; c < 10; c++) begin
      drive(c, 0, 3, 1'b1, c == 0);
      tests += 3;
      if ({b.valid_o, b.busy_o, b.done_o, b.overflow_o} !== {m_valid(), m_busy, m_done, m_ovf}) begin
        fails++; $display("FAIL basic_model_flags c=%0d got %b exp %b", c, {b.valid_o, b.busy_o, b.done_o, b.overflow_o}, {m_valid(), m_busy, m_done, m_ovf});
      end
      if (b.out !== m_out()) begin fails++; $display("FAIL basic_model_out c=%0d got %h exp %h", c, b.out, m_out()); end
      if ({b.valid_o, b.busy_o, b.done_o, b.overflow_o} !== {c >= 4 && c <= 6, c >= 1 && c <= 6, c == 7, 1'b0}) begin
        fails++; $display("FAIL basic_timing c=%0d got %b", c, {b.valid_o, b.busy_o, b.done_o, b.overflow_o});
      end
      if (c >= 4 && c <= 6) begin
        tests++;
        if (b.out !== {32'(32'h300 + c - 4), 32'(32'h200 + c - 4), 32'(32'h100 + c - 4), 32'(c - 4)}) begin
          fails++; $display("FAIL basic_row c=%0d got %h", c, b.out);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [LANES*WIDTH-1:0] prev;
    bit stalled = 0;
    salt = $urandom;
    got.delete();
    for (int c = 0; c < 16; c++) begin
      drive(c, 0, 4, !(c >= 3 && c <= 7), c == 0);
      tests += 2;
      if ({b.valid_o, b.busy_o, b.done_o, b.overflow_o} !== {m_valid(), m_busy, m_done, m_ovf}) begin
        fails++; $display("FAIL stall_model_flags c=%0d got %b exp %b", c, {b.valid_o, b.busy_o, b.done_o, b.overflow_o}, {m_valid(), m_busy, m_done, m_ovf});
      end
      if (b.out !== m_out()) begin fails++; $display("FAIL stall_model_out c=%0d got %h exp %h", c, b.out, m_out()); end
      if (stalled) begin
        tests++;
        if (b.valid_o !== 1'b1 || b.out !== prev) begin
          fails++; $display("FAIL stall_hold c=%0d got %b/%h exp 1/%h", c, b.valid_o, b.out, prev);
        end
      end
      stalled = b.valid_o && !b.ready_i;
      prev = b.out;
      if (b.valid_o && b.ready_i) got.push_back(b.out);
      tick();
    end
    tests += 2;
    if (got.size() != 4) begin fails++; $display("FAIL stall_rows got %0d exp 4", got.size()); end
    if (b.overflow_o !== 1'b0) begin fails++; $display("FAIL stall_ovf got %b exp 0", b.overflow_o); end
    for (int r = 0; r < got.size() && r < 4; r++) begin
      tests++;
      if (got[r] !== row(r)) begin fails++; $display("FAIL stall_row%0d got %h exp %h", r, got[r], row(r)); end
    end
  endtask

  task automatic test_overflow();
    salt = $urandom;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      drive(c, 0, 6, c >= 12, c == 0);
      tests += 2;
      if ({b.valid_o, b.busy_o, b.done_o, b.overflow_o} !== {m_valid(), m_busy, m_done, m_ovf}) begin
        fails++; $display("FAIL ovf_model_flags c=%0d got %b exp %b", c, {b.valid_o, b.busy_o, b.done_o, b.overflow_o}, {m_valid(), m_busy, m_done, m_ovf});
      end
      if (b.out !== m_out()) begin fails++; $display("FAIL ovf_model_out c=%0d got %h exp %h", c, b.out, m_out()); end
      if (c < 12) begin
        tests++;
        if (b.overflow_o !== (c >= 5)) begin fails++; $display("FAIL ovf_flag c=%0d got %b exp %b", c, b.overflow_o, c >= 5); end
      end
      if (b.valid_o && b.ready_i) got.push_back(b.out);
      tick();
    end
    tests++;
    if (got.size() != 4) begin fails++; $display("FAIL ovf_rows got %0d exp 4", got.size()); end
    for (int r = 0; r < got.size() && r < 4; r++) begin
      tests++;
      if (got[r][WIDTH-1:0] !== lane_val(0, r)) begin
        fails++; $display("FAIL ovf_lane0_%0d got %h exp %h", r, got[r][WIDTH-1:0], lane_val(0, r));
      end
    end
    rst = 1;
    drive(0, 1, 0, 1'b0, 1'b0);
    tick();
    rst = 0;
  endtask

  task automatic test_zero();
    for (int c = 0; c < 5; c++) begin
      drive(c, 0, 0, 1'b1, c == 0);
      tests += 2;
      if ({b.valid_o, b.busy_o, b.done_o, b.overflow_o} !== {m_valid(), m_busy, m_done, m_ovf}) begin
        fails++; $display("FAIL zero_model_flags c=%0d got %b exp %b", c, {b.valid_o, b.busy_o, b.done_o, b.overflow_o}, {m_valid(), m_busy, m_done, m_ovf});
      end
      if ({b.valid_o, b.busy_o, b.done_o} !== {1'b0, c == 1, c == 1}) begin
        fails++; $display("FAIL zero_timing c=%0d got %b", c, {b.valid_o, b.busy_o, b.done_o});
      end
      tick();
    end
  endtask

  task automatic test_flush();
    salt = $urandom;
    got.delete();
    for (int c = 0; c < 17; c++) begin
      if (c < 6) drive(c, 0, 8, 1'b1, c == 0);
      else if (c < 8) drive(c, 0, 0, 1'b1, 1'b0);
      else drive(c, 8, 2, 1'b1, c == 8);
      b.flush = c == 5;
      tests += 2;
      if ({b.valid_o, b.busy_o, b.done_o, b.overflow_o} !== {m_valid(), m_busy, m_done, m_ovf}) begin
        fails++; $display("FAIL flush_model_flags c=%0d got %b exp %b", c, {b.valid_o, b.busy_o, b.done_o, b.overflow_o}, {m_valid(), m_busy, m_done, m_ovf});
      end
      if (b.out !== m_out()) begin fails++; $display("FAIL flush_model_out c=%0d got %h exp %h", c, b.out, m_out()); end
      if (c == 6) begin
        tests++;
        if ({b.valid_o, b.busy_o, b.overflow_o} !== 3'b000) begin
          fails++; $display("FAIL flush_clear got %b exp 000", {b.valid_o, b.busy_o, b.overflow_o});
        end
      end
      if (c >= 8) begin
        tests++;
        if (b.done_o !== (c == 14)) begin fails++; $display("FAIL flush_done c=%0d got %b exp %b", c, b.done_o, c == 14); end
        if (b.valid_o && b.ready_i) got.push_back(b.out);
      end
      tick();
    end
    b.flush = 0;
    tests++;
    if (got.size() != 2) begin fails++; $display("FAIL flush_rows got %0d exp 2", got.size()); end
    for (int r = 0; r < got.size() && r < 2; r++) begin
      tests++;
      if (got[r] !== row(r)) begin fails++; $display("FAIL flush_row%0d got %h exp %h", r, got[r], row(r)); end
    end
  endtask

  task automatic test_reset_mid();
    salt = $urandom;
    for (int c = 0; c < 14; c++) begin
      if (c <= 5) drive(c, 0, 5, 1'b1, c == 0);
      else begin
        drive(c, 0, 0, 1'b1, 1'b0);
        b.lane_valid_i = LANES'($urandom);
        b.lane_data_i = {$urandom, $urandom, $urandom, $urandom};
      end
      rst = c == 5;
      tests += 2;
      if ({b.valid_o, b.busy_o, b.done_o, b.overflow_o} !== {m_valid(), m_busy, m_done, m_ovf}) begin
        fails++; $display("FAIL rstmid_model_flags c=%0d got %b exp %b", c, {b.valid_o, b.busy_o, b.done_o, b.overflow_o}, {m_valid(), m_busy, m_done, m_ovf});
      end
      if (b.out !== m_out()) begin fails++; $display("FAIL rstmid_model_out c=%0d got %h exp %h", c, b.out, m_out()); end
      if (c >= 6) begin
        tests++;
        if ({b.valid_o, b.busy_o, b.done_o, b.overflow_o} !== 4'b0000 || b.out !== '0) begin
          fails++; $display("FAIL rstmid_idle c=%0d got %b/%h exp 0000/0", c, {b.valid_o, b.busy_o, b.done_o, b.overflow_o}, b.out);
        end
      end
      tick();
    end
    rst = 0;
  endtask

  task automatic test_random();
    int e;
    for (int it = 0; it < 8; it++) begin
      salt = $urandom;
      e = $urandom_range(1, 8);
      for (int c = 0; c < 40; c++) begin
        drive(c, 0, e, $urandom_range(0, 3) != 0, c == 0 || c == 2);
        if (c == 2) b.enable_cycles_in = $urandom;
        tests += 2;
        if ({b.valid_o, b.busy_o, b.done_o, b.overflow_o} !== {m_valid(), m_busy, m_done, m_ovf}) begin
          fails++; $display("FAIL rand%0d_flags c=%0d got %b exp %b", it, c, {b.valid_o, b.busy_o, b.done_o, b.overflow_o}, {m_valid(), m_busy, m_done, m_ovf});
        end
        if (b.out !== m_out()) begin fails++; $display("FAIL rand%0d_out c=%0d got %h exp %h", it, c, b.out, m_out()); end
        tick();
      end
      rst = 1;
      drive(0, 1, 0, 1'b0, 1'b0);
      tick();
      rst = 0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_zero();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
